// File: rtl/mrd_rdx_bfp_track_if.sv
// Bus bundle for the BFP tracker of the mixed-radix butterfly stage.
// master : stage controller / bench side (drives sop, samples, core status)
// slave  : mrd_rdx_bfp_track (drives FIFO head, margin, exponent, status)
// Signals:
//   sop, in_valid, in_idx_addr            -> stage start, side-info write
//   core_val, core_exp                    -> DFT core exponent report
//   dat_valid, dat_real, dat_imag         -> twiddled data, pops side-info
//   out_idx_addr                          <- realigned side-info (show-ahead)
//   margin_q, margin_upd                  <- burst headroom and update pulse
//   exp_q, exp_sat                        <- stage exponent, sticky saturation
//   fifo_cnt, err_ovf, err_udf            <- FIFO occupancy and sticky errors
interface mrd_rdx_bfp_track_if #(
    parameter int NCH        = 5,
    parameter int wD         = 18,
    parameter int wIDX       = 3,
    parameter int wADDR      = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_MARGIN = 3,
    parameter int wEXP       = 4
);
    localparam int wIA   = NCH * (wIDX + wADDR);
    localparam int wMARG = $clog2(MAX_MARGIN + 1);
    localparam int wCNT  = $clog2(FIFO_DEPTH) + 1;

    logic                  sop;
    logic                  in_valid;
    logic [wIA-1:0]        in_idx_addr;
    logic                  core_val;
    logic [wEXP-1:0]       core_exp;
    logic                  dat_valid;
    logic [NCH*wD-1:0]     dat_real;
    logic [NCH*wD-1:0]     dat_imag;
    logic [wIA-1:0]        out_idx_addr;
    logic [wMARG-1:0]      margin_q;
    logic                  margin_upd;
    logic [wEXP-1:0]       exp_q;
    logic                  exp_sat;
    logic [wCNT-1:0]       fifo_cnt;
    logic                  err_ovf;
    logic                  err_udf;

    modport master (
        output sop, in_valid, in_idx_addr, core_val, core_exp,
               dat_valid, dat_real, dat_imag,
        input  out_idx_addr, margin_q, margin_upd, exp_q, exp_sat,
               fifo_cnt, err_ovf, err_udf
    );

    modport slave (
        input  sop, in_valid, in_idx_addr, core_val, core_exp,
               dat_valid, dat_real, dat_imag,
        output out_idx_addr, margin_q, margin_upd, exp_q, exp_sat,
               fifo_cnt, err_ovf, err_udf
    );
endinterface

// File: rtl/mrd_rdx_bfp_track.sv
// Block-floating-point tracker for the mixed-radix 2/3/4/5 butterfly stage.
// Keeps per-sample bank idx/addr side-info in a show-ahead FIFO while the
// samples run through the DFT core and twiddle multiplier, measures the
// headroom of each returning burst, and tracks the stage exponent.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (clears everything incl. error flags)
//   bus  - mrd_rdx_bfp_track_if.slave (see interface header)

// Headroom of one signed component: leading zeros of |x| below the sign
// bit, capped at MAX_MARGIN. The most negative value saturates to max.
module mrd_rdx_bfp_lane #(
    parameter int wD         = 18,
    parameter int MAX_MARGIN = 3,
    parameter int wMARG      = 2
) (
    input  logic signed [wD-1:0] x,
    output logic [wMARG-1:0]     m
);
    logic [wD-1:0] a;

    always_comb begin
        if (x == {1'b1, {(wD-1){1'b0}}})
            a = {1'b0, {(wD-1){1'b1}}};
        else if (x[wD-1])
            a = -x;
        else
            a = x;
        // a >= 2^(wD-2-i) means the first set bit is at or above wD-2-i;
        // scanning downward leaves the smallest such i.
        m = wMARG'(MAX_MARGIN);
        for (int i = MAX_MARGIN - 1; i >= 0; i--)
            if (a >= (wD'(1) << (wD - 2 - i)))
                m = wMARG'(i);
    end
endmodule

module mrd_rdx_bfp_track #(
    parameter int NCH        = 5,
    parameter int wD         = 18,
    parameter int wIDX       = 3,
    parameter int wADDR      = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_MARGIN = 3,
    parameter int wEXP       = 4,
    parameter int EXP_ACCUM  = 0
) (
    input logic                 clk,
    input logic                 rst,
    mrd_rdx_bfp_track_if.slave  bus
);
    localparam int wIA   = NCH * (wIDX + wADDR);
    localparam int wMARG = $clog2(MAX_MARGIN + 1);
    localparam int wPTR  = $clog2(FIFO_DEPTH);
    localparam int wCNT  = wPTR + 1;
    localparam int NV    = 2 * NCH;

    // ---------------- side-info FIFO ----------------
    logic [wIA-1:0]  mem [FIFO_DEPTH];
    logic [wPTR-1:0] wr_ptr, rd_ptr, wr_addr;
    logic [wCNT-1:0] cnt;
    logic [wIA-1:0]  last_pop;
    logic            empty, full, do_rd, do_wr, mem_we;
    logic            err_ovf, err_udf;

    assign empty   = (cnt == '0);
    assign full    = (cnt == wCNT'(FIFO_DEPTH));
    assign do_rd   = bus.dat_valid & ~empty & ~bus.sop;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_wr   = bus.in_valid & ~bus.sop & (~full | do_rd);
    // sop flushes first, so a coincident write lands in slot 0.
    assign mem_we  = bus.in_valid & (bus.sop | do_wr);
    assign wr_addr = bus.sop ? '0 : wr_ptr;

    always_ff @(posedge clk)
        if (mem_we)
            mem[wr_addr] <= bus.in_idx_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            last_pop <= '0;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
        end else if (bus.sop) begin
            rd_ptr <= '0;
            wr_ptr <= wPTR'(bus.in_valid);
            cnt    <= wCNT'(bus.in_valid);
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_pop <= mem[rd_ptr];
            end
            cnt <= cnt + wCNT'(do_wr) - wCNT'(do_rd);
            if (bus.in_valid & ~do_wr)
                err_ovf <= 1'b1;
            if (bus.dat_valid & empty)
                err_udf <= 1'b1;
        end
    end

    // Show-ahead head; an empty FIFO keeps presenting the last popped entry.
    assign bus.out_idx_addr = empty ? last_pop : mem[rd_ptr];
    assign bus.fifo_cnt     = cnt;
    assign bus.err_ovf      = err_ovf;
    assign bus.err_udf      = err_udf;

    // ---------------- margin pipeline ----------------
    logic [wMARG-1:0] lane_m [NV];
    logic [wMARG-1:0] m_min, m1, acc, margin_q;
    logic [1:0]       vld_pipe;   // [0] = v1, [1] = v1 delayed
    logic             margin_upd;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        mrd_rdx_bfp_lane #(.wD(wD), .MAX_MARGIN(MAX_MARGIN), .wMARG(wMARG)) u_re (
            .x (bus.dat_real[g*wD +: wD]),
            .m (lane_m[2*g])
        );
        mrd_rdx_bfp_lane #(.wD(wD), .MAX_MARGIN(MAX_MARGIN), .wMARG(wMARG)) u_im (
            .x (bus.dat_imag[g*wD +: wD]),
            .m (lane_m[2*g+1])
        );
    end

    always_comb begin
        m_min = wMARG'(MAX_MARGIN);
        for (int i = 0; i < NV; i++)
            if (lane_m[i] < m_min)
                m_min = lane_m[i];
    end

    // sop drops any burst in flight, so no update is issued for it.
    always_ff @(posedge clk) begin
        if (rst || bus.sop) begin
            vld_pipe   <= '0;
            m1         <= '0;
            acc        <= '0;
            margin_q   <= '0;
            margin_upd <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[0], bus.dat_valid};
            m1         <= m_min;
            margin_upd <= 1'b0;
            if (vld_pipe[0] & ~vld_pipe[1])
                acc <= m1;
            else if (vld_pipe[0])
                acc <= (m1 < acc) ? m1 : acc;
            else if (vld_pipe[1]) begin
                margin_q   <= acc;
                margin_upd <= 1'b1;
            end
        end
    end

    assign bus.margin_q   = margin_q;
    assign bus.margin_upd = margin_upd;

    // ---------------- stage exponent ----------------
    logic            core_val_d, exp_sat;
    logic [wEXP-1:0] exp_q;
    logic [wEXP:0]   exp_sum;

    assign exp_sum = {1'b0, exp_q} + {1'b0, bus.core_exp};

    // core_val_d keeps tracking through sop so a held core_val is not
    // re-captured once the stage restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_val_d <= 1'b0;
            exp_q      <= '0;
            exp_sat    <= 1'b0;
        end else begin
            core_val_d <= bus.core_val;
            if (bus.sop) begin
                exp_q   <= '0;
                exp_sat <= 1'b0;
            end else if (bus.core_val & ~core_val_d) begin
                if (EXP_ACCUM == 0)
                    exp_q <= bus.core_exp;
                else if (exp_sum[wEXP]) begin
                    exp_q   <= '1;
                    exp_sat <= 1'b1;
                end else
                    exp_q <= exp_sum[wEXP-1:0];
            end
        end
    end

    assign bus.exp_q   = exp_q;
    assign bus.exp_sat = exp_sat;
endmodule
